// File: rtl/sha3_pkg.sv
// sha3_pkg: shared SHA3 sponge variant tables, padding bytes and controller state codes
package sha3_pkg;
  typedef enum logic [1:0] {SHA224, SHA256, SHA384, SHA512} sha3_mode_e;
  localparam logic [7:0] PAD_DS = 8'h06;
  localparam logic [7:0] PAD_END = 8'h80;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ABSORB = 3'd1;
  localparam logic [2:0] PAD = 3'd2;
  localparam logic [2:0] PERM = 3'd3;
  localparam logic [2:0] SQUEEZE = 3'd4;
  function automatic logic [6:0] rate_words(input sha3_mode_e m);
    return m == SHA224 ? 7'd72 : m == SHA256 ? 7'd68 : m == SHA384 ? 7'd52 : 7'd36;
  endfunction
  function automatic logic [6:0] digest_words(input sha3_mode_e m);
    return m == SHA224 ? 7'd14 : m == SHA256 ? 7'd16 : m == SHA384 ? 7'd24 : 7'd32;
  endfunction
endpackage

// File: rtl/sha3_sponge_ctrl.sv
// sha3_sponge_ctrl: SHA3 absorb/pad/permute/squeeze sequencer driving a shared Keccak-f[1600] core
module sha3_sponge_ctrl
  import sha3_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ADDR_W = 7
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [1:0]        ID,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WIDTH-1:0]  s_data,
  input  logic [1:0]        s_keep,
  input  logic              s_last,
  output logic              state_clr,
  output logic              xor_we,
  output logic [ADDR_W-1:0] xor_addr,
  output logic [WIDTH-1:0]  xor_data,
  output logic              perm_start,
  input  logic              perm_done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WIDTH-1:0]  m_data,
  output logic              m_last,
  output logic              busy
);
  logic [2:0] state_q, state_d;
  logic [1:0] id_q, id_d;
  logic [ADDR_W-1:0] wc_q, wc_d, xor_addr_q, xor_addr_d, r_last;
  logic [5:0] oc_q, oc_d, d_last;
  logic [WIDTH-1:0] xor_data_q, xor_data_d;
  logic fin_q, fin_d, padp_q, padp_d, ph_q, ph_d;
  logic xor_we_q, xor_we_d, state_clr_q, state_clr_d, perm_start_q, perm_start_d;
  logic wc_end, last00, last01, last11;
  assign r_last = ADDR_W'(rate_words(sha3_mode_e'(id_q)) - 7'd1);
  assign d_last = 6'(digest_words(sha3_mode_e'(id_q)) - 7'd1);
  assign wc_end = wc_q == r_last;
  assign last00 = s_last && s_keep == 2'b00;
  assign last01 = s_last && s_keep == 2'b01;
  assign last11 = s_last && !last00 && !last01;
  assign s_ready = state_q == ABSORB;
  assign m_valid = state_q == SQUEEZE;
  assign m_data = m_valid ? rd_data : '0;
  assign m_last = m_valid && oc_q == d_last;
  assign rd_addr = ADDR_W'(oc_q);
  assign busy = state_q != IDLE;
  assign state_clr = state_clr_q;
  assign xor_we = xor_we_q;
  assign xor_addr = xor_addr_q;
  assign xor_data = xor_data_q;
  assign perm_start = perm_start_q;
  always_comb begin
    state_d = state_q;
    id_d = id_q;
    wc_d = wc_q;
    oc_d = oc_q;
    fin_d = fin_q;
    padp_d = padp_q;
    ph_d = ph_q;
    state_clr_d = 1'b0;
    perm_start_d = 1'b0;
    xor_we_d = 1'b0;
    xor_addr_d = '0;
    xor_data_d = '0;
    case (state_q)
      IDLE: if (s_valid) begin
        state_clr_d = 1'b1;
        id_d = ID;
        wc_d = '0;
        fin_d = 1'b0;
        padp_d = 1'b0;
        state_d = ABSORB;
      end
      ABSORB: if (s_valid) begin
        xor_we_d = !last00;
        xor_addr_d = wc_q;
        xor_data_d = last01 ? {wc_end ? PAD_DS | PAD_END : PAD_DS, s_data[7:0]} : s_data;
        wc_d = last00 || last01 ? wc_q : wc_q + ADDR_W'(1);
        fin_d = s_last && !(last11 && wc_end);
        padp_d = last11 && wc_end;
        ph_d = last01;
        state_d = wc_end && !last00 ? PERM : s_last ? PAD : ABSORB;
      end
      PAD: begin
        xor_we_d = 1'b1;
        xor_addr_d = ph_q ? r_last : wc_q;
        xor_data_d = ph_q ? {PAD_END, 8'h00} : {wc_end ? PAD_END : 8'h00, PAD_DS};
        ph_d = 1'b1;
        state_d = ph_q || wc_end ? PERM : PAD;
      end
      PERM: begin
        perm_start_d = xor_we_q;
        if (perm_done && !xor_we_q && !perm_start_q) begin
          wc_d = '0;
          ph_d = 1'b0;
          fin_d = fin_q || padp_q;
          padp_d = 1'b0;
          state_d = fin_q ? SQUEEZE : padp_q ? PAD : ABSORB;
        end
      end
      SQUEEZE: if (m_ready) begin
        oc_d = m_last ? '0 : oc_q + 6'd1;
        state_d = m_last ? IDLE : SQUEEZE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      id_q <= '0;
      wc_q <= '0;
      oc_q <= '0;
      fin_q <= 1'b0;
      padp_q <= 1'b0;
      ph_q <= 1'b0;
      state_clr_q <= 1'b0;
      perm_start_q <= 1'b0;
      xor_we_q <= 1'b0;
      xor_addr_q <= '0;
      xor_data_q <= '0;
    end else begin
      state_q <= state_d;
      id_q <= id_d;
      wc_q <= wc_d;
      oc_q <= oc_d;
      fin_q <= fin_d;
      padp_q <= padp_d;
      ph_q <= ph_d;
      state_clr_q <= state_clr_d;
      perm_start_q <= perm_start_d;
      xor_we_q <= xor_we_d;
      xor_addr_q <= xor_addr_d;
      xor_data_q <= xor_data_d;
    end
  end
endmodule

// File: doc/sha3_sponge_ctrl.md
Name: sha3_sponge_ctrl

Overview:
Sequencer that drives the shared Keccak-f[1600] permutation core for SHA3-224/256/384/512. It accepts a byte-packed 16-bit message stream and XOR-writes the words into the core state at rate-block granularity. It inserts SHA3 padding (0x06 … 0x80), issues one permutation per rate block, then streams the digest out 16 bits at a time. It sits between the AXI-stream ingress and the permutation core inside the AXI_SHA wrapper.

Parameters:
WIDTH, 16, stream and state-port word width in bits; only 16 is supported.
ADDR_W, 7, state word address width; the state holds 100 words of 16 bits.

Ports:
ACLK  in  1  clock
ARESETn  in  1  async active-low reset
ID  in  2  variant: 0=224, 1=256, 2=384, 3=512; latched at message start
s_valid  in  1  message word valid
s_ready  out  1  message word accepted when s_valid&&s_ready
s_data  in  16  message bytes; byte0=[7:0] comes first in message order
s_keep  in  2  valid bytes on the last word: 00, 01 or 11; ignored (treated as 11) when s_last=0
s_last  in  1  final word of message
state_clr  out  1  one-cycle pulse that zeroes the core state
xor_we  out  1  XOR xor_data into state word xor_addr
xor_addr  out  ADDR_W  state word index 0..99
xor_data  out  16  data to XOR
perm_start  out  1  one-cycle pulse to start a permutation
perm_done  in  1  one-cycle pulse from the core when the permutation completes
rd_addr  out  ADDR_W  digest read address
rd_data  in  16  combinational core state read of rd_addr
m_valid  out  1  digest word valid
m_ready  in  1  digest sink ready
m_data  out  16  digest word; equals rd_data
m_last  out  1  final digest word
busy  out  1  high whenever state≠IDLE

Behaviour:
- Reset value 0 for all outputs, counters and state; FSM returns to IDLE. Reset is async and may arrive mid-operation; the core is not touched, and the next message issues state_clr anyway.
- Rate R in words: 72 / 68 / 52 / 36. Digest length D in words: 14 / 16 / 24 / 32, by ID.
- IDLE: s_ready=0.
  - On s_valid: pulse state_clr, latch ID, wc=0, go to ABSORB.
  - The word is not consumed in this cycle.
- ABSORB: s_ready=1.
  - An accepted word at cycle t produces xor_we=1, xor_addr=wc, xor_data=word at t+1 (registered). wc then increments.
  - Non-last word with wc==R-1: go to PERM; s_ready=0 from t+1.
  - s_last word: go to PAD, with fin=1.
- PAD: emits at most two writes, one per cycle. Zero pad words are never written.
  - Let p = index of the first pad byte.
  - keep=01 → p lies in the same word; xor_data = {0x06, byte0}, or {0x86, byte0} if that word is R-1. This replaces the plain write for that word.
  - keep=11 or 00 → the pad word is the next word. Write {0x00,0x06} there, or {0x80,0x06} if it is R-1. keep=00 writes nothing for the last word itself.
  - If the word carrying 0x06 is not R-1, a separate write of {0x80,0x00} goes to R-1.
  - If a keep=11 last word lands at R-1: go to PERM with fin=0. After the permutation, PAD restarts at wc=0 with {0x00,0x06} and {0x80,0x00} at R-1.
- PERM: perm_start pulses in the first cycle after the final xor write of the block, then the FSM waits for perm_done.
  - perm_done outside this wait is ignored.
  - On perm_done: wc=0, then go to ABSORB (fin=0) or SQUEEZE (fin=1).
- SQUEEZE: rd_addr=oc, m_valid=1, m_data=rd_data, m_last=(oc==D-1).
  - oc increments on m_valid&&m_ready.
  - A handshake on m_last returns the FSM to IDLE; the next message's state_clr may occur the following cycle.
  - No second permutation is needed, since D≤R.
- Simultaneous events: s_valid while busy outside ABSORB is held off by s_ready=0. ID changes during a message have no effect.

Decomposition:
- Shared package sha3_pkg holds:
  - sha3_mode_e (SHA224..SHA512)
  - the rate_words() and digest_words() functions
  - constants PAD_DS=8'h06, PAD_END=8'h80
  - state enum {IDLE, ABSORB, PAD, PERM, SQUEEZE}
- No sub-module; the FSM and the pad-word generator fit one module.

Test Plan:
- Empty message, ID=1, s_keep=00, s_last=1 → state_clr; writes (0, 0x0006), (67, 0x8000); one perm_start. Digest with a bit-exact core model: first m_data=0xffa7, full digest a7ffc6f8…8434a, m_last on word 15.
- "abc", ID=1: words 0x6261 (keep11), 0x0063 (keep01, last) → writes (0, 0x6261), (1, 0x0663), (67, 0x8000); digest 3a985da7…11431532, first m_data=0x983a.
- ID=3, 71-byte message → last word at addr 35 with keep01 gives xor_data=0x86xx and no separate 0x80 write; exactly one perm_start.
- ID=3, 72-byte message → two perm_starts; the second block writes only (0, 0x0006) and (35, 0x8000).
- m_ready toggled 1/0 each cycle in SQUEEZE (ID=0) → m_data held stable while stalled, 14 words total, m_last only on word 13.
- ARESETn asserted mid-ABSORB → all outputs 0 immediately. The next "abc" message hashes correctly.
